alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_pkg.sv | 22 ++
 rtl/alu_pipe_core.sv | 58 +++++
 rtl/alu_pipe.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for the alu_pipe block: the 3-bit opcode encoding.
package alu_pipe_pkg;

  localparam int unsigned OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_INV_A = 3'd2,
    OP_OR_B  = 3'd3,
    OP_AND   = 3'd4,
    OP_XOR   = 3'd5,
    OP_ACC   = 3'd6,
    OP_CLR   = 3'd7
  } opcode_t;

  // True for the ops that write the accumulator.
  function automatic logic is_acc_op(input opcode_t op);
    return (op == OP_ACC) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational op evaluation for alu_pipe.
// Optional feature macro: ALU_PIPE_SAT_EN (ACC saturates instead of wrapping).
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH:0]   acc,
  output logic [WIDTH:0]   result,
  output logic             ovf
);

  localparam int unsigned RW = WIDTH + 1;
  localparam int unsigned SW = WIDTH + 2;

  logic [RW-1:0] w_a_ext;
  logic [RW-1:0] w_b_ext;
  logic [SW-1:0] w_sum;
  logic          w_acc_ovf;

  assign w_a_ext   = {A[WIDTH-1], A};
  assign w_b_ext   = {B[WIDTH-1], B};
  // One guard bit beyond the accumulator width exposes any wrap.
  assign w_sum     = {acc[WIDTH], acc} + {{2{A[WIDTH-1]}}, A};
  assign w_acc_ovf = w_sum[SW-1] ^ w_sum[SW-2];

  // Result select; ovf only ever comes from the accumulate path.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (opcode)
      OP_ADD:   result = w_a_ext + w_b_ext;
      OP_SUB:   result = w_a_ext - w_b_ext;
      OP_INV_A: result = ~w_a_ext;
      OP_OR_B:  result = RW'(|B);
      OP_AND:   result = w_a_ext & w_b_ext;
      OP_XOR:   result = w_a_ext ^ w_b_ext;
      OP_ACC: begin
        ovf = w_acc_ovf;
`ifdef ALU_PIPE_SAT_EN
        if (w_acc_ovf) begin
          result = w_sum[SW-1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}};
        end else begin
          result = w_sum[RW-1:0];
        end
`else
        result = w_sum[RW-1:0];
`endif
      end
      OP_CLR:   result = '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with an internal accumulator.
// Optional feature macro: ALU_PIPE_SAT_EN (ACC saturates instead of wrapping).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   C,
  output logic             zero,
  output logic             ovf
);

  logic             r_s1_valid;
  opcode_t          r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_s2_valid;
  logic [WIDTH:0]   r_c;
  logic             r_zero;
  logic             r_ovf;

  logic [WIDTH:0]   r_acc;

  logic             w_s2_load;
  logic             w_s1_load;
  logic [WIDTH:0]   w_result;
  logic             w_ovf;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  assign out_valid = r_s2_valid;
  assign C         = r_c;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .opcode (r_s1_op),
    .A      (r_s1_a),
    .B      (r_s1_b),
    .acc    (r_acc),
    .result (w_result),
    .ovf    (w_ovf)
  );

  // Stage 1: capture opcode and operands on an input transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= opcode;
        r_s1_a  <= A;
        r_s1_b  <= B;
      end
    end
  end

  // Stage 2: register the evaluated result and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_c        <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_c    <= w_result;
        r_zero <= (w_result == '0);
        r_ovf  <= w_ovf;
      end
    end
  end

  // Accumulator commits only when an ACC/CLR op advances into stage 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (r_s1_valid && w_s2_load && is_acc_op(r_s1_op)) begin
      r_acc <= w_result;
    end
  end

endmodule
